// File: rtl/piso_serializer.sv
// Parallel-in, serial-out transmitter: takes a WIDTH-bit word over valid/ready and shifts it out one bit per enabled cycle.
// Latency: first bit on sout the cycle after acceptance; a frame takes exactly WIDTH shift_en cycles.
// Backpressure: load_ready only in IDLE or on an enabled last-bit cycle; shift_en=0 freezes the shifter.
//
// Ports:
//   clk, rst                  rising-edge clock, asynchronous active-high reset
//   load_data/valid/ready     parallel word handshake
//   shift_en                  bit-rate enable
//   sout, sout_valid,         serial bit, frame-bit strobe,
//   sout_last, busy           final-bit strobe, frame in progress
module piso_serializer #(
    parameter int WIDTH     = 4,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic             shift_en,
    output logic             sout,
    output logic             sout_valid,
    output logic             sout_last,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    cnt_q,   cnt_d;
    logic             accept;

    // All outputs are decoded straight from the registers.
    assign busy       = (state_q == SHIFT);
    assign sout_valid = busy;
    assign sout_last  = busy && (cnt_q == LAST_IDX);
    assign sout       = busy && (LSB_FIRST ? shreg_q[0] : shreg_q[WIDTH-1]);

    // Ready in IDLE regardless of shift_en; mid-frame only when the last bit
    // is actually leaving this cycle, which gives gapless back-to-back frames.
    assign load_ready = !rst && (!busy || (sout_last && shift_en));
    assign accept     = load_valid && load_ready;

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        if (accept) begin
            shreg_d = load_data;
            cnt_d   = '0;
            state_d = SHIFT;
        end else if (busy && shift_en) begin
            if (sout_last) begin
                state_d = IDLE;
            end else begin
                shreg_d = LSB_FIRST ? {1'b0, shreg_q[WIDTH-1:1]}
                                    : {shreg_q[WIDTH-2:0], 1'b0};
                cnt_d   = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: two instances, 4-bit LSB-first (ch0) and 8-bit MSB-first (ch1).
// The reference model is a queue of pending {bit,last} entries per instance, filled when a word is accepted.
// A negedge monitor compares every DUT output against the head of that queue each cycle.
module tb_piso_serializer;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // channel 0: WIDTH=4, LSB first
    logic [3:0] ld0;
    logic       lv0, se0, lr0, so0, sv0, sl0, bz0;
    // channel 1: WIDTH=8, MSB first
    logic [7:0] ld1;
    logic       lv1, se1, lr1, so1, sv1, sl1, bz1;

    piso_serializer #(.WIDTH(4), .LSB_FIRST(1'b1)) dut0 (
        .clk(clk), .rst(rst), .load_data(ld0), .load_valid(lv0), .load_ready(lr0),
        .shift_en(se0), .sout(so0), .sout_valid(sv0), .sout_last(sl0), .busy(bz0));

    piso_serializer #(.WIDTH(8), .LSB_FIRST(1'b0)) dut1 (
        .clk(clk), .rst(rst), .load_data(ld1), .load_valid(lv1), .load_ready(lr1),
        .shift_en(se1), .sout(so1), .sout_valid(sv1), .sout_last(sl1), .busy(bz1));

    int vectors     = 0;
    int miscompares = 0;

    // pending frame bits per channel: entry = {bit, last}
    logic [1:0] q0[$];
    logic [1:0] q1[$];

    // SIPO sink on channel 0, same clock
    logic [3:0] sipo;
    always @(posedge clk) if (sv0 && se0) sipo <= {so0, sipo[3:1]};

    task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int qsize(input int ch);
        return (ch == 0) ? q0.size() : q1.size();
    endfunction

    // ready as the model sees it: nothing pending, or only the last bit left and it leaves now
    function automatic bit mrdy(input int ch);
        bit se = (ch == 0) ? se0 : se1;
        return !rst && (qsize(ch) == 0 || (qsize(ch) == 1 && se));
    endfunction

    // reference model
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q0.delete();
            q1.delete();
        end else begin
            bit r0, r1;
            r0 = mrdy(0);
            r1 = mrdy(1);
            if (q0.size() != 0 && se0) void'(q0.pop_front());
            if (q1.size() != 0 && se1) void'(q1.pop_front());
            if (lv0 && r0) for (int i = 0; i < 4; i++) q0.push_back({ld0[i], i == 3});
            if (lv1 && r1) for (int i = 0; i < 8; i++) q1.push_back({ld1[7-i], i == 7});
        end
    end

    // monitor
    always @(negedge clk) begin
        #1;
        check("ch0 sout_valid", 8'(sv0), 8'(q0.size() != 0));
        check("ch0 busy", 8'(bz0), 8'(q0.size() != 0));
        check("ch0 sout", 8'(so0), 8'(q0.size() != 0 ? q0[0][1] : 1'b0));
        check("ch0 sout_last", 8'(sl0), 8'(q0.size() != 0 ? q0[0][0] : 1'b0));
        check("ch0 load_ready", 8'(lr0), 8'(mrdy(0)));
        check("ch1 sout_valid", 8'(sv1), 8'(q1.size() != 0));
        check("ch1 busy", 8'(bz1), 8'(q1.size() != 0));
        check("ch1 sout", 8'(so1), 8'(q1.size() != 0 ? q1[0][1] : 1'b0));
        check("ch1 sout_last", 8'(sl1), 8'(q1.size() != 0 ? q1[0][0] : 1'b0));
        check("ch1 load_ready", 8'(lr1), 8'(mrdy(1)));
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_se(input int ch, input int pct);
        bit v = ($urandom_range(99) < pct);
        if (ch == 0) se0 = v; else se1 = v;
    endtask

    task automatic set_lv(input int ch, input logic v);
        if (ch == 0) lv0 = v; else lv1 = v;
    endtask

    // present a word and return at the negedge after it was accepted (load_valid left high)
    task automatic send(input int ch, input logic [7:0] w, input int pct);
        bit will;
        if (ch == 0) ld0 = w[3:0]; else ld1 = w;
        set_lv(ch, 1'b1);
        for (int c = 0; c < 200; c++) begin
            set_se(ch, pct);
            will = mrdy(ch);
            tick();
            if (will) return;
        end
        vectors++;
        miscompares++;
        $display("FAIL send timeout ch%0d: got no accept expected accept within 200 cycles", ch);
    endtask

    task automatic wait_idle(input int ch, input int pct);
        set_lv(ch, 1'b0);
        for (int c = 0; c < 400; c++) begin
            if (qsize(ch) == 0) return;
            set_se(ch, pct);
            tick();
        end
        vectors++;
        miscompares++;
        $display("FAIL drain timeout ch%0d: got busy expected idle within 400 cycles", ch);
    endtask

    task automatic rand_traffic(input int ch, input int n);
        for (int k = 0; k < n; k++) begin
            if ($urandom_range(2) == 0) begin
                set_lv(ch, 1'b0);
                repeat ($urandom_range(1, 3)) begin
                    set_se(ch, 70);
                    tick();
                end
            end
            send(ch, 8'($urandom), 60 + $urandom_range(40));
        end
        wait_idle(ch, 70);
    endtask

    initial begin
        lv0 = 0; lv1 = 0; se0 = 1; se1 = 1; ld0 = '0; ld1 = '0;
        rst = 1'b1;
        #2;
        // reset state
        check("rst sout_valid", 8'(sv0), 8'd0);
        check("rst busy", 8'(bz0), 8'd0);
        check("rst load_ready ch0", 8'(lr0), 8'd0);
        check("rst load_ready ch1", 8'(lr1), 8'd0);
        check("rst sout", 8'(so0), 8'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // 1011 LSB first, SIPO sink ends up holding the word
        send(0, 8'b1011, 100);
        wait_idle(0, 100);
        check("sipo word", 8'(sipo), 8'b1011);

        // back-to-back A then 5
        send(0, 8'hA, 100);
        send(0, 8'h5, 100);
        wait_idle(0, 100);
        check("sipo b2b", 8'(sipo), 8'h5);

        // stall three cycles mid-frame on 0110
        send(0, 8'b0110, 100);
        lv0 = 0;
        se0 = 1;
        tick();
        tick();
        se0 = 0;
        repeat (3) begin
            tick();
            check("stall sout holds", 8'(so0), 8'd1);
        end
        wait_idle(0, 100);

        // async reset mid-frame, away from both clock edges
        send(0, 8'b1110, 100);
        lv0 = 0;
        se0 = 1;
        tick();
        tick();
        #2 rst = 1'b1;
        #1;
        check("midrst sout_valid", 8'(sv0), 8'd0);
        check("midrst busy", 8'(bz0), 8'd0);
        check("midrst sout_last", 8'(sl0), 8'd0);
        check("midrst load_ready", 8'(lr0), 8'd0);
        rst = 1'b0;
        #1;
        check("postrst load_ready", 8'(lr0), 8'd1);
        @(negedge clk);
        send(0, 8'b0001, 100);
        wait_idle(0, 100);
        check("sipo after rst", 8'(sipo), 8'b0001);

        // MSB first C3; later words held while busy must not be sampled early
        send(1, 8'hC3, 100);
        ld1 = 8'h5A;
        repeat (3) tick();
        send(1, 8'h96, 100);
        wait_idle(1, 100);

        // randomized traffic on both channels at once
        fork
            rand_traffic(0, 40);
            rand_traffic(1, 25);
        join
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
